// File: rtl/ysyx_25020037_pkg.sv
// Shared RV32I decode constants and ALU operation encoding for the issue stage.
// ALU_OP_* are bit positions inside the one-hot alu_op vector.
package ysyx_25020037_pkg;

  localparam int ALU_OP_W = 17;

  localparam int ALU_OP_ADD  = 0;
  localparam int ALU_OP_SUB  = 1;
  localparam int ALU_OP_SLT  = 2;
  localparam int ALU_OP_SLTU = 3;
  localparam int ALU_OP_AND  = 4;
  localparam int ALU_OP_OR   = 5;
  localparam int ALU_OP_XOR  = 6;
  localparam int ALU_OP_SLL  = 7;
  localparam int ALU_OP_SRL  = 8;
  localparam int ALU_OP_SRA  = 9;
  localparam int ALU_OP_LUI  = 10;
  localparam int ALU_OP_BNE  = 11;
  localparam int ALU_OP_BEQ  = 12;
  localparam int ALU_OP_BGE  = 13;
  localparam int ALU_OP_BGEU = 14;
  localparam int ALU_OP_BLT  = 15;
  localparam int ALU_OP_BLTU = 16;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef struct packed {
    logic [ALU_OP_W-1:0] alu_op;
    logic                double_cal;
    logic [31:0]         src1;
    logic [31:0]         src2;
    logic [31:0]         src3;
    logic [31:0]         src4;
    logic [4:0]          rd;
    logic                rf_we;
    logic                jump;
    logic [31:0]         jump_target;
    logic                illegal;
  } dec_bundle_t;

  function automatic logic [ALU_OP_W-1:0] op_bit(input int idx);
    return {{(ALU_OP_W-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/ysyx_25020037_alu_dec.sv
// Combinational RV32I decoder: instruction, pc and register data to ALU operand bundle.
// Unsupported encodings collapse to an all-zero bundle with only illegal raised.
module ysyx_25020037_alu_dec
  import ysyx_25020037_pkg::*;
(
  input  logic [31:0]         inst,
  input  logic [31:0]         pc,
  input  logic [31:0]         rs1_data,
  input  logic [31:0]         rs2_data,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                double_cal,
  output logic [31:0]         src1,
  output logic [31:0]         src2,
  output logic [31:0]         src3,
  output logic [31:0]         src4,
  output logic [4:0]          rd,
  output logic                rf_we,
  output logic                jump,
  output logic [31:0]         jump_target,
  output logic                illegal
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic [31:0] imm_b;
  logic [31:0] imm_j;
  logic [31:0] shamt;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];
  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_u  = {inst[31:12], 12'b0};
  assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign shamt  = {27'b0, inst[24:20]};

  always_comb begin
    alu_op      = '0;
    double_cal  = 1'b0;
    src1        = '0;
    src2        = '0;
    src3        = '0;
    src4        = '0;
    rd          = '0;
    rf_we       = 1'b0;
    jump        = 1'b0;
    jump_target = '0;
    illegal     = 1'b0;

    unique case (opcode)
      OPC_OP: begin
        src1  = rs1_data;
        src2  = rs2_data;
        rf_we = 1'b1;
        if (funct7 == F7_BASE) begin
          unique case (funct3)
            F3_ADD:  alu_op = op_bit(ALU_OP_ADD);
            F3_SLL:  alu_op = op_bit(ALU_OP_SLL);
            F3_SLT:  alu_op = op_bit(ALU_OP_SLT);
            F3_SLTU: alu_op = op_bit(ALU_OP_SLTU);
            F3_XOR:  alu_op = op_bit(ALU_OP_XOR);
            F3_SR:   alu_op = op_bit(ALU_OP_SRL);
            F3_OR:   alu_op = op_bit(ALU_OP_OR);
            F3_AND:  alu_op = op_bit(ALU_OP_AND);
            default: illegal = 1'b1;
          endcase
        end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
          alu_op = op_bit(ALU_OP_SUB);
        end else if (funct7 == F7_ALT && funct3 == F3_SR) begin
          alu_op = op_bit(ALU_OP_SRA);
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        src1  = rs1_data;
        src2  = imm_i;
        rf_we = 1'b1;
        unique case (funct3)
          F3_ADD:  alu_op = op_bit(ALU_OP_ADD);
          F3_SLT:  alu_op = op_bit(ALU_OP_SLT);
          F3_SLTU: alu_op = op_bit(ALU_OP_SLTU);
          F3_XOR:  alu_op = op_bit(ALU_OP_XOR);
          F3_OR:   alu_op = op_bit(ALU_OP_OR);
          F3_AND:  alu_op = op_bit(ALU_OP_AND);
          F3_SLL: begin
            src2 = shamt;
            if (funct7 == F7_BASE) alu_op = op_bit(ALU_OP_SLL);
            else                   illegal = 1'b1;
          end
          F3_SR: begin
            src2 = shamt;
            if (funct7 == F7_BASE)     alu_op = op_bit(ALU_OP_SRL);
            else if (funct7 == F7_ALT) alu_op = op_bit(ALU_OP_SRA);
            else                       illegal = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      OPC_LUI: begin
        alu_op = op_bit(ALU_OP_LUI);
        src2   = imm_u;
        rf_we  = 1'b1;
      end
      OPC_AUIPC: begin
        alu_op = op_bit(ALU_OP_ADD);
        src1   = pc;
        src2   = imm_u;
        rf_we  = 1'b1;
      end
      OPC_BRANCH: begin
        double_cal = 1'b1;
        src1       = pc;
        src2       = imm_b;
        src3       = rs1_data;
        src4       = rs2_data;
        unique case (funct3)
          F3_BEQ:  alu_op = op_bit(ALU_OP_BEQ);
          F3_BNE:  alu_op = op_bit(ALU_OP_BNE);
          F3_BLT:  alu_op = op_bit(ALU_OP_BLT);
          F3_BGE:  alu_op = op_bit(ALU_OP_BGE);
          F3_BLTU: alu_op = op_bit(ALU_OP_BLTU);
          F3_BGEU: alu_op = op_bit(ALU_OP_BGEU);
          default: illegal = 1'b1;
        endcase
      end
      OPC_JAL: begin
        alu_op      = op_bit(ALU_OP_ADD);
        src1        = pc;
        src2        = 32'd4;
        rf_we       = 1'b1;
        jump        = 1'b1;
        jump_target = pc + imm_j;
      end
      OPC_JALR: begin
        alu_op      = op_bit(ALU_OP_ADD);
        src1        = pc;
        src2        = 32'd4;
        rf_we       = 1'b1;
        jump        = 1'b1;
        jump_target = (rs1_data + imm_i) & ~32'h1;
        if (funct3 != 3'b000) illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase

    if (illegal) begin
      alu_op      = '0;
      double_cal  = 1'b0;
      src1        = '0;
      src2        = '0;
      src3        = '0;
      src4        = '0;
      rf_we       = 1'b0;
      jump        = 1'b0;
      jump_target = '0;
    end

    // rd is only meaningful when something is written back; x0 writes are suppressed.
    rf_we = rf_we & (inst[11:7] != 5'd0);
    rd    = rf_we ? inst[11:7] : 5'd0;
  end

endmodule

// File: rtl/ysyx_25020037_alu_issue.sv
// Issue stage: decodes the incoming bundle and holds it in a valid/ready register toward EXU.
// flush beats load; a draining bundle is replaced in the same cycle when a new one arrives.
module ysyx_25020037_alu_issue
  import ysyx_25020037_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = 32'h8000_0000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [XLEN-1:0]     in_inst,
  input  logic [XLEN-1:0]     in_pc,
  input  logic [XLEN-1:0]     in_rs1_data,
  input  logic [XLEN-1:0]     in_rs2_data,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                double_cal,
  output logic [XLEN-1:0]     alu_src1,
  output logic [XLEN-1:0]     alu_src2,
  output logic [XLEN-1:0]     alu_src3,
  output logic [XLEN-1:0]     alu_src4,
  output logic [4:0]          out_rd,
  output logic                out_rf_we,
  output logic                out_jump,
  output logic [XLEN-1:0]     out_jump_target,
  output logic [XLEN-1:0]     out_pc,
  output logic                out_illegal
);

  dec_bundle_t dec_p0;

  ysyx_25020037_alu_dec u_dec (
    .inst        (in_inst),
    .pc          (in_pc),
    .rs1_data    (in_rs1_data),
    .rs2_data    (in_rs2_data),
    .alu_op      (dec_p0.alu_op),
    .double_cal  (dec_p0.double_cal),
    .src1        (dec_p0.src1),
    .src2        (dec_p0.src2),
    .src3        (dec_p0.src3),
    .src4        (dec_p0.src4),
    .rd          (dec_p0.rd),
    .rf_we       (dec_p0.rf_we),
    .jump        (dec_p0.jump),
    .jump_target (dec_p0.jump_target),
    .illegal     (dec_p0.illegal)
  );

  assign in_ready = ~out_valid | out_ready;

  // ---- p0 (decode) -> p1 (issue register) ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid       <= 1'b0;
      alu_op          <= '0;
      double_cal      <= 1'b0;
      alu_src1        <= '0;
      alu_src2        <= '0;
      alu_src3        <= '0;
      alu_src4        <= '0;
      out_rd          <= '0;
      out_rf_we       <= 1'b0;
      out_jump        <= 1'b0;
      out_jump_target <= '0;
      out_pc          <= RESET_PC;
      out_illegal     <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid       <= 1'b1;
      alu_op          <= dec_p0.alu_op;
      double_cal      <= dec_p0.double_cal;
      alu_src1        <= dec_p0.src1;
      alu_src2        <= dec_p0.src2;
      alu_src3        <= dec_p0.src3;
      alu_src4        <= dec_p0.src4;
      out_rd          <= dec_p0.rd;
      out_rf_we       <= dec_p0.rf_we;
      out_jump        <= dec_p0.jump;
      out_jump_target <= dec_p0.jump_target;
      out_pc          <= in_pc;
      out_illegal     <= dec_p0.illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ysyx_25020037_alu_issue.sv
// Scoreboard bench for the issue stage: decode table, stall/back-to-back, flush and async reset.
module tb_ysyx_25020037_alu_issue;

  typedef struct packed {
    logic [16:0] op;
    logic        dc;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] s3;
    logic [31:0] s4;
    logic [4:0]  rd;
    logic        we;
    logic        j;
    logic [31:0] jt;
    logic [31:0] pc;
    logic        ill;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] alu_op;
  logic        double_cal;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [31:0] alu_src3;
  logic [31:0] alu_src4;
  logic [4:0]  out_rd;
  logic        out_rf_we;
  logic        out_jump;
  logic [31:0] out_jump_target;
  logic [31:0] out_pc;
  logic        out_illegal;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  localparam logic [31:0] ADD_X3 = 32'h002081B3;

  ysyx_25020037_alu_issue dut (
    .clock           (clock),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_inst         (in_inst),
    .in_pc           (in_pc),
    .in_rs1_data     (in_rs1_data),
    .in_rs2_data     (in_rs2_data),
    .flush           (flush),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .alu_op          (alu_op),
    .double_cal      (double_cal),
    .alu_src1        (alu_src1),
    .alu_src2        (alu_src2),
    .alu_src3        (alu_src3),
    .alu_src4        (alu_src4),
    .out_rd          (out_rd),
    .out_rf_we       (out_rf_we),
    .out_jump        (out_jump),
    .out_jump_target (out_jump_target),
    .out_pc          (out_pc),
    .out_illegal     (out_illegal)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(logic [16:0] op, logic dc, logic [31:0] s1, logic [31:0] s2,
                              logic [31:0] s3, logic [31:0] s4, logic [4:0] rd, logic we,
                              logic j, logic [31:0] jt, logic [31:0] pc, logic ill);
    exp_t e;
    e.op = op; e.dc = dc; e.s1 = s1; e.s2 = s2; e.s3 = s3; e.s4 = s4;
    e.rd = rd; e.we = we; e.j = j; e.jt = jt; e.pc = pc; e.ill = ill;
    return e;
  endfunction

  function automatic exp_t mk_add(logic [31:0] a, logic [31:0] b, logic [31:0] pc);
    return mk(17'h00001, 1'b0, a, b, 32'd0, 32'd0, 5'd3, 1'b1, 1'b0, 32'd0, pc, 1'b0);
  endfunction

  function automatic exp_t obs();
    return mk(alu_op, double_cal, alu_src1, alu_src2, alu_src3, alu_src4, out_rd, out_rf_we,
              out_jump, out_jump_target, out_pc, out_illegal);
  endfunction

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc,
                       input logic [31:0] a, input logic [31:0] b);
    in_valid    = 1'b1;
    in_inst     = inst;
    in_pc       = pc;
    in_rs1_data = a;
    in_rs2_data = b;
  endtask

  task automatic test_reset();
    exp_t got;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    in_inst = '0; in_pc = '0; in_rs1_data = '0; in_rs2_data = '0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %b required 1", in_ready);
    end
    repeat (2) @(negedge clock);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got %b required 0", out_valid);
    end
    got = obs();
    checks++;
    if (got !== mk(17'h0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 32'd0, 32'h8000_0000, 1'b0)) begin
      errors++; $display("FAIL reset_outputs got %h required reset bundle with pc 80000000", got);
    end
    reset = 1'b0;
  endtask

  task automatic test_decode();
    logic [31:0] ti[13];
    logic [31:0] tp[13];
    logic [31:0] ta[13];
    logic [31:0] tb[13];
    exp_t        te[13];
    exp_t        got;
    exp_t        e;
    int          n;
    ti[0]  = 32'h002081B3; tp[0]  = 32'h8000_0000; ta[0]  = 32'd5;        tb[0]  = 32'd7;
    te[0]  = mk(17'h00001, 0, 32'd5, 32'd7, 0, 0, 5'd3, 1, 0, 0, 32'h8000_0000, 0);
    ti[1]  = 32'h40435293; tp[1]  = 32'h8000_0004; ta[1]  = 32'h8000_0000; tb[1]  = 32'd9;
    te[1]  = mk(17'h00200, 0, 32'h8000_0000, 32'd4, 0, 0, 5'd5, 1, 0, 0, 32'h8000_0004, 0);
    ti[2]  = 32'h00208463; tp[2]  = 32'h8000_0000; ta[2]  = 32'd11;       tb[2]  = 32'd22;
    te[2]  = mk(17'h01000, 1, 32'h8000_0000, 32'd8, 32'd11, 32'd22, 5'd0, 0, 0, 0, 32'h8000_0000, 0);
    ti[3]  = 32'h010000EF; tp[3]  = 32'h8000_0010; ta[3]  = 32'd1;        tb[3]  = 32'd2;
    te[3]  = mk(17'h00001, 0, 32'h8000_0010, 32'd4, 0, 0, 5'd1, 1, 1, 32'h8000_0020, 32'h8000_0010, 0);
    ti[4]  = 32'h123453B7; tp[4]  = 32'h8000_0014; ta[4]  = 32'd3;        tb[4]  = 32'd4;
    te[4]  = mk(17'h00400, 0, 32'd0, 32'h1234_5000, 0, 0, 5'd7, 1, 0, 0, 32'h8000_0014, 0);
    ti[5]  = 32'hFFFFF117; tp[5]  = 32'h8000_0020; ta[5]  = 32'd3;        tb[5]  = 32'd4;
    te[5]  = mk(17'h00001, 0, 32'h8000_0020, 32'hFFFF_F000, 0, 0, 5'd2, 1, 0, 0, 32'h8000_0020, 0);
    ti[6]  = 32'hFFD280E7; tp[6]  = 32'h8000_0030; ta[6]  = 32'h0000_1000; tb[6]  = 32'd4;
    te[6]  = mk(17'h00001, 0, 32'h8000_0030, 32'd4, 0, 0, 5'd1, 1, 1, 32'h0000_0FFC, 32'h8000_0030, 0);
    ti[7]  = 32'h00208033; tp[7]  = 32'h8000_0034; ta[7]  = 32'd3;        tb[7]  = 32'd4;
    te[7]  = mk(17'h00001, 0, 32'd3, 32'd4, 0, 0, 5'd0, 0, 0, 0, 32'h8000_0034, 0);
    ti[8]  = 32'h40208233; tp[8]  = 32'h8000_0038; ta[8]  = 32'd10;       tb[8]  = 32'd3;
    te[8]  = mk(17'h00002, 0, 32'd10, 32'd3, 0, 0, 5'd4, 1, 0, 0, 32'h8000_0038, 0);
    ti[9]  = 32'h022081B3; tp[9]  = 32'h8000_003C; ta[9]  = 32'd10;       tb[9]  = 32'd3;
    te[9]  = mk(17'h00000, 0, 0, 0, 0, 0, 5'd0, 0, 0, 0, 32'h8000_003C, 1);
    ti[10] = 32'h00012083; tp[10] = 32'h8000_0040; ta[10] = 32'd10;       tb[10] = 32'd3;
    te[10] = mk(17'h00000, 0, 0, 0, 0, 0, 5'd0, 0, 0, 0, 32'h8000_0040, 1);
    ti[11] = 32'hFFF0A313; tp[11] = 32'h8000_0044; ta[11] = 32'h55;        tb[11] = 32'd3;
    te[11] = mk(17'h00004, 0, 32'h55, 32'hFFFF_FFFF, 0, 0, 5'd6, 1, 0, 0, 32'h8000_0044, 0);
    ti[12] = 32'hFE20EEE3; tp[12] = 32'h8000_0048; ta[12] = 32'd1;        tb[12] = 32'd2;
    te[12] = mk(17'h10000, 1, 32'h8000_0048, 32'hFFFF_FFFC, 32'd1, 32'd2, 5'd0, 0, 0, 0, 32'h8000_0048, 0);

    for (int i = 0; i < 13; i++) begin
      @(negedge clock);
      out_ready = 1'b1;
      drive(ti[i], tp[i], ta[i], tb[i]);
      q.push_back(te[i]);
      @(negedge clock);
      in_valid = 1'b0;
      n = 0;
      while (out_valid !== 1'b1 && n < 4) begin
        @(negedge clock);
        n++;
      end
      checks++;
      if (out_valid !== 1'b1) begin
        errors++; $display("FAIL decode_%0d_valid got %b required 1", i, out_valid);
        q.delete();
      end else begin
        got = obs();
        e   = q.pop_front();
        checks++;
        if (got !== e) begin
          errors++; $display("FAIL decode_%0d got %h required %h", i, got, e);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t got;
    exp_t e;
    @(negedge clock);
    out_ready = 1'b0;
    drive(ADD_X3, 32'h100, 32'd100, 32'd200);
    q.push_back(mk_add(32'd100, 32'd200, 32'h100));
    @(negedge clock);
    drive(ADD_X3, 32'h104, 32'd1, 32'd2);
    q.push_back(mk_add(32'd1, 32'd2, 32'h104));
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (in_ready !== 1'b0) begin
        errors++; $display("FAIL stall_in_ready_%0d got %b required 0", k, in_ready);
      end
      got = obs();
      checks++;
      if (out_valid !== 1'b1 || got !== q[0]) begin
        errors++; $display("FAIL stall_hold_%0d valid %b got %h required %h", k, out_valid, got, q[0]);
      end
      @(negedge clock);
    end
    out_ready = 1'b1;
    got = obs();
    e   = q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || got !== e) begin
      errors++; $display("FAIL b2b_first valid %b got %h required %h", out_valid, got, e);
    end
    @(negedge clock);
    got = obs();
    e   = q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || got !== e) begin
      errors++; $display("FAIL b2b_second valid %b got %h required %h", out_valid, got, e);
    end
    drive(ADD_X3, 32'h108, 32'hFFFF_FFFF, 32'h8000_0000);
    q.push_back(mk_add(32'hFFFF_FFFF, 32'h8000_0000, 32'h108));
    @(negedge clock);
    in_valid = 1'b0;
    got = obs();
    e   = q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || got !== e) begin
      errors++; $display("FAIL b2b_third valid %b got %h required %h", out_valid, got, e);
    end
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_drain got %b required 0", out_valid);
    end
  endtask

  task automatic test_flush();
    exp_t got;
    exp_t e;
    @(negedge clock);
    out_ready = 1'b1;
    flush = 1'b1;
    drive(ADD_X3, 32'h200, 32'd1, 32'd1);
    @(negedge clock);
    flush = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_incoming got %b required 0", out_valid);
    end
    out_ready = 1'b0;
    drive(ADD_X3, 32'h204, 32'd2, 32'd2);
    @(negedge clock);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL flush_preload got %b required 1", out_valid);
    end
    flush = 1'b1;
    drive(ADD_X3, 32'h208, 32'd3, 32'd3);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL flush_in_ready got %b required 0", in_ready);
    end
    @(negedge clock);
    flush = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_held got %b required 0", out_valid);
    end
    out_ready = 1'b1;
    drive(ADD_X3, 32'h20C, 32'd4, 32'd5);
    q.push_back(mk_add(32'd4, 32'd5, 32'h20C));
    @(negedge clock);
    in_valid = 1'b0;
    got = obs();
    e   = q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || got !== e) begin
      errors++; $display("FAIL flush_recover valid %b got %h required %h", out_valid, got, e);
    end
  endtask

  task automatic test_async_reset();
    exp_t got;
    @(negedge clock);
    out_ready = 1'b0;
    drive(32'h010000EF, 32'h8000_0010, 32'd0, 32'd0);
    @(negedge clock);
    in_valid = 1'b0;
    got = obs();
    checks++;
    if (out_valid !== 1'b1 || got !== mk(17'h00001, 0, 32'h8000_0010, 32'd4, 0, 0, 5'd1, 1, 1, 32'h8000_0020, 32'h8000_0010, 0)) begin
      errors++; $display("FAIL areset_preload valid %b got %h required held jal bundle", out_valid, got);
    end
    #2;
    reset = 1'b1;
    #1;
    got = obs();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL areset_ctrl valid %b ready %b required 0 1", out_valid, in_ready);
    end
    checks++;
    if (got !== mk(17'h0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 32'd0, 32'h8000_0000, 1'b0)) begin
      errors++; $display("FAIL areset_outputs got %h required reset bundle with pc 80000000", got);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_decode();
    test_back_to_back();
    test_flush();
    test_async_reset();
    checks++;
    if (q.size() != 0) begin
      errors++; $display("FAIL scoreboard_leftover got %0d required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
